fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/instr_split.sv | 22 ++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int OPP_W   = 5;
  localparam int REG_W   = 3;
  localparam int RES_W   = 2;

  // Instruction word layout: opp[15:11] R1[10:8] R2[7:5] QR[4:2] RES[1:0]
  localparam int OPP_MSB = 15;
  localparam int OPP_LSB = 11;
  localparam int R1_MSB  = 10;
  localparam int R1_LSB  = 8;
  localparam int R2_MSB  = 7;
  localparam int R2_LSB  = 5;
  localparam int QR_MSB  = 4;
  localparam int QR_LSB  = 2;
  localparam int RES_MSB = 1;
  localparam int RES_LSB = 0;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOT  = 5'd6,
    OP_SHL  = 5'd7,
    OP_SHR  = 5'd8,
    OP_LD   = 5'd9,
    OP_ST   = 5'd10,
    OP_JMP  = 5'd11,
    OP_JZ   = 5'd12,
    OP_JNZ  = 5'd13,
    OP_CMP  = 5'd14,
    OP_MOV  = 5'd15,
    OP_HLT  = 5'd16,
    OP_RST  = 5'd17,
    OP_SETH = 5'd18,
    OP_SETL = 5'd19
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_split.sv
// Splits a 16-bit instruction word into opcode and register/result fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow i_word.
// Ports: i_word (instruction in); o_opp, o_r1, o_r2, o_qr, o_res (fields out).
module instr_split
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_word,
  output logic [OPP_W-1:0]   o_opp,
  output logic [REG_W-1:0]   o_r1,
  output logic [REG_W-1:0]   o_r2,
  output logic [REG_W-1:0]   o_qr,
  output logic [RES_W-1:0]   o_res
);

  assign o_opp = i_word[OPP_MSB:OPP_LSB];
  assign o_r1  = i_word[R1_MSB:R1_LSB];
  assign o_r2  = i_word[R2_MSB:R2_LSB];
  assign o_qr  = i_word[QR_MSB:QR_LSB];
  assign o_res = i_word[RES_MSB:RES_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests words from imem, holds one decoded instruction for control.
// Latency: dec_valid the cycle after imem_valid; >= 3 cycles/instruction with 1-cycle memory.
// Backpressure: dec_ready=0 holds the fields and blocks the next fetch; jmp_taken squashes/redirects.
// Ports: clk/rst_n; imem_req/imem_addr/imem_valid/imem_data (memory side);
//        opp/R1/R2/QR/RES/dec_valid/dec_ready (control side); jmp_taken/jmp_target; halted.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HLT_OP   = 5'd16,
  parameter logic [4:0]  RST_OP   = 5'd17
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [4:0]  opp,
  output logic [2:0]  R1,
  output logic [2:0]  R2,
  output logic [2:0]  QR,
  output logic [1:0]  RES,
  output logic        dec_valid,
  input  logic        dec_ready,
  input  logic        jmp_taken,
  input  logic [15:0] jmp_target,
  output logic        halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [15:0]  r_pc;
  logic [15:0]  w_pc_nxt;
  logic [15:0]  r_ir;
  logic         r_discard;
  logic         w_discard_nxt;
  logic         r_req_out;
  logic         w_rsp;
  logic         w_hs;
  logic         w_load_ir;

  // A response only counts once our request has been seen by memory for at
  // least one edge; a valid arriving before that belongs to an abandoned request.
  assign w_rsp     = imem_valid & r_req_out;
  assign dec_valid = (r_state == ST_ISSUE) & ~jmp_taken;
  assign w_hs      = dec_valid & dec_ready;
  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign halted    = (r_state == ST_HALT);

  instr_split u_split (
    .i_word (r_ir),
    .o_opp  (opp),
    .o_r1   (R1),
    .o_r2   (R2),
    .o_qr   (QR),
    .o_res  (RES)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_load_ir     = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (w_rsp) begin
          // The response always retires the outstanding request.
          w_discard_nxt = 1'b0;
          if (jmp_taken) begin
            w_pc_nxt = jmp_target;
          end else if (!r_discard) begin
            w_load_ir   = 1'b1;
            w_pc_nxt    = r_pc + 16'd1;
            w_state_nxt = ST_ISSUE;
          end
        end else if (jmp_taken) begin
          // Request is in flight for the old PC; its data must be thrown away.
          w_pc_nxt      = jmp_target;
          w_discard_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (jmp_taken) begin
          w_pc_nxt    = jmp_target;
          w_state_nxt = ST_FETCH;
        end else if (w_hs) begin
          if (opp == HLT_OP) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_FETCH;
            if (opp == RST_OP) begin
              w_pc_nxt = RESET_PC;
            end
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_req_out <= 1'b0;
      r_ir      <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      // imem_req is a level, so memory has seen it at this edge unless a
      // response just retired it (a new request then starts next cycle).
      r_req_out <= (r_state == ST_FETCH) & ~w_rsp;
      if (w_load_ir) begin
        r_ir <= imem_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [4:0]  opp;
  logic [2:0]  R1;
  logic [2:0]  R2;
  logic [2:0]  QR;
  logic [1:0]  RES;
  logic        dec_valid;
  logic        dec_ready;
  logic        jmp_taken;
  logic [15:0] jmp_target;
  logic        halted;

  logic [15:0] fields;
  assign fields = {opp, R1, R2, QR, RES};

  int n_vec = 0;
  int n_err = 0;

  // Memory model: one request at a time, valid pulses for one cycle,
  // no new request is accepted in the valid cycle.
  logic [15:0] mem [logic [15:0]];
  logic        mem_en   = 1'b0;
  int          mem_lat  = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [15:0] mem_a    = 16'h0000;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_valid <= 1'b1;
        imem_data  <= rd(mem_a);
        mem_busy   <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (mem_en && imem_req && !imem_valid) begin
      if (mem_lat <= 1) begin
        imem_valid <= 1'b1;
        imem_data  <= rd(imem_addr);
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_a    <= imem_addr;
      end
    end
  end

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .opp        (opp),
    .R1         (R1),
    .R2         (R2),
    .QR         (QR),
    .RES        (RES),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_dec(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (dec_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic ok;
    rst_n      = 1'b0;
    dec_ready  = 1'b0;
    jmp_taken  = 1'b0;
    jmp_target = 16'h0000;
    mem[16'h0000] = 16'h0B2D;
    mem[16'h0001] = 16'h1234;
    mem[16'h0002] = 16'hDEAD;
    mem[16'h0005] = 16'h8800;
    mem[16'h0010] = 16'h8000;
    mem[16'h0040] = 16'h2A5C;
    mem[16'hFFFF] = 16'h4321;

    // Reset state
    repeat (2) tick();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ir", fields, 16'h0000);

    // First fetch, 1-cycle memory
    rst_n = 1'b1; mem_en = 1'b1; dec_ready = 1'b1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 16'h0000);
    tick(); tick();
    chk("t1_dec_valid", dec_valid, 1);
    chk("t1_opp", opp, 1);
    chk("t1_r1", R1, 3);
    chk("t1_r2", R2, 1);
    chk("t1_qr", QR, 3);
    chk("t1_res", RES, 1);
    tick();
    chk("t1_next_req", imem_req, 1);
    chk("t1_next_addr", imem_addr, 16'h0001);

    // Stall: fields held, no new request
    dec_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_dec_valid", dec_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_fields", fields, 16'h1234);
      tick();
    end
    dec_ready = 1'b1;
    tick();
    chk("stall_release_req", imem_req, 1);
    chk("stall_release_addr", imem_addr, 16'h0002);
    chk("stall_release_dv", dec_valid, 0);

    // Redirect while a 3-cycle read is in flight
    mem_lat = 3;
    tick();
    jmp_target = 16'h0040; jmp_taken = 1'b1;
    tick();
    jmp_taken = 1'b0;
    chk("jmp_addr", imem_addr, 16'h0040);
    chk("jmp_req", imem_req, 1);
    wait_dec(16, ok);
    chk("jmp_dec_timeout", ok, 1);
    chk("jmp_fields", fields, 16'h2A5C);
    mem_lat = 1;
    tick();
    chk("jmp_next_addr", imem_addr, 16'h0041);

    // Redirect in the same cycle as imem_valid; PC wrap at FFFF
    tick();
    jmp_target = 16'hFFFF; jmp_taken = 1'b1;
    tick();
    jmp_taken = 1'b0;
    chk("samecyc_addr", imem_addr, 16'hFFFF);
    chk("samecyc_req", imem_req, 1);
    tick(); tick();
    chk("samecyc_dec_valid", dec_valid, 1);
    chk("samecyc_fields", fields, 16'h4321);
    tick();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_req", imem_req, 1);

    // Squash of an instruction held in ISSUE
    dec_ready = 1'b0;
    tick(); tick();
    chk("squash_pre_dv", dec_valid, 1);
    jmp_target = 16'h0005; jmp_taken = 1'b1; dec_ready = 1'b1;
    #1;
    chk("squash_dec_valid", dec_valid, 0);
    tick();
    jmp_taken = 1'b0;
    chk("squash_addr", imem_addr, 16'h0005);

    // RST opcode at address 5
    tick(); tick();
    chk("rstop_dec_valid", dec_valid, 1);
    chk("rstop_opp", opp, 17);
    tick();
    chk("rstop_addr", imem_addr, 16'h0000);
    chk("rstop_req", imem_req, 1);

    // Redirect in the first FETCH cycle, then HLT
    jmp_target = 16'h0010; jmp_taken = 1'b1;
    tick();
    jmp_taken = 1'b0;
    tick(); tick(); tick();
    chk("discard_dec_valid", dec_valid, 1);
    chk("discard_fields", fields, 16'h8000);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_dec_valid", dec_valid, 0);
    jmp_target = 16'h0020; jmp_taken = 1'b1;
    tick();
    jmp_taken = 1'b0;
    chk("halt_jmp_halted", halted, 1);
    chk("halt_jmp_addr", imem_addr, 16'h0011);
    repeat (3) tick();
    chk("halt_hold_req", imem_req, 0);

    // rst_n pulse leaves HALT
    mem_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("pulse_halted", halted, 0);
    chk("pulse_req", imem_req, 1);
    chk("pulse_addr", imem_addr, 16'h0000);
    tick();
    rst_n = 1'b1; mem_en = 1'b1;
    tick(); tick();
    chk("resume_dec_valid", dec_valid, 1);
    chk("resume_fields", fields, 16'h0B2D);

    // Reset during a pending read; its late valid must be ignored
    tick();
    chk("late_pre_addr", imem_addr, 16'h0001);
    mem_lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("late_abandon_addr", imem_addr, 16'h0000);
    tick(); tick();
    rst_n = 1'b1; mem_lat = 1;
    tick();
    chk("late_ignored_dv", dec_valid, 0);
    tick(); tick();
    chk("late_fetch_dv", dec_valid, 1);
    chk("late_fetch_fields", fields, 16'h0B2D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
